exec_stage: RTL and testbench

Integer execute stage sitting directly downstream of operand fetch. Accepts one operation per handshake (opcode, destination operand, source operand, destination register, operand size), computes a size-masked result plus ZF/SF/CF, and presents it in an output register for writeback. Single-cycle ALU ops; multiply is iterative and stalls the input side.

---
 rtl/exec_stage_if.sv | 38 +++
 rtl/exec_stage.sv | 253 +++++++++++++++++++++++++
 tb/tb_exec_stage.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_stage_if.sv
// exec_stage_if: operation handshake into the execute stage and the
// result/writeback handshake out of it.
interface exec_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_nop;
  logic [7:0]  in_oper;
  logic [63:0] in_oper1;
  logic [63:0] in_oper2;
  logic [3:0]  in_dstreg;
  logic [1:0]  in_size;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [3:0]  out_dstreg;
  logic        out_we;
  logic [2:0]  out_flags;

  modport master (
    output in_valid, in_nop, in_oper,
    output in_oper1, in_oper2,
    output in_dstreg, in_size,
    output out_ready,
    input  in_ready, out_valid,
    input  out_result, out_dstreg,
    input  out_we, out_flags
  );

  modport slave (
    input  in_valid, in_nop, in_oper,
    input  in_oper1, in_oper2,
    input  in_dstreg, in_size,
    input  out_ready,
    output in_ready, out_valid,
    output out_result, out_dstreg,
    output out_we, out_flags
  );
endinterface

// File: rtl/exec_stage.sv
// exec_stage: size-masked integer ALU with flags and an output register.
// Define EXEC_MUL_EN to build the iterative multiplier (opcode 08).
module exec_stage #(
  parameter int MUL_BITS = 4
) (
  input logic         clk,
  input logic         reset,
  exec_stage_if.slave io
);

  if (MUL_BITS != 1 && MUL_BITS != 2 &&
      MUL_BITS != 4 && MUL_BITS != 8) begin : g_bad
    $error("exec_stage: illegal MUL_BITS");
  end

  function automatic logic [63:0] wmask(
    input logic [1:0] sz
  );
    logic [63:0] m;
    unique case (sz)
      2'd0: m = 64'h0000_0000_0000_00ff;
      2'd1: m = 64'h0000_0000_0000_ffff;
      2'd2: m = 64'h0000_0000_ffff_ffff;
      default: m = '1;
    endcase
    return m;
  endfunction

  function automatic logic msb_of(
    input logic [63:0] r,
    input logic [1:0]  sz
  );
    logic b;
    unique case (sz)
      2'd0: b = r[7];
      2'd1: b = r[15];
      2'd2: b = r[31];
      default: b = r[63];
    endcase
    return b;
  endfunction

  // 8/16-bit ops keep the upper bits; 32-bit zero-extends
  function automatic logic [63:0] merge(
    input logic [63:0] raw,
    input logic [63:0] old,
    input logic [1:0]  sz
  );
    logic [63:0] m;
    m = wmask(sz);
    if (sz[1]) return raw & m;
    return (old & ~m) | (raw & m);
  endfunction

  logic [63:0] a, b, m, am, bm, raw;
  logic [64:0] sum;
  logic [6:0]  w, cnt, idx;
  logic        cf, legal, mov;
  logic [63:0] alu_res;
  logic [2:0]  alu_flags;
`ifdef EXEC_MUL_EN
  logic        is_mul;
`endif

  always_comb begin
    a     = io.in_oper1;
    b     = io.in_oper2;
    m     = wmask(io.in_size);
    am    = a & m;
    bm    = b & m;
    w     = 7'd8 << io.in_size;
    cnt   = (io.in_size == 2'd3) ?
            {1'b0, b[5:0]} : {2'b0, b[4:0]};
    sum   = {1'b0, am} + {1'b0, bm};
    raw   = '0;
    idx   = '0;
    cf    = 1'b0;
    legal = 1'b1;
    mov   = 1'b0;
`ifdef EXEC_MUL_EN
    is_mul = 1'b0;
`endif
    unique case (io.in_oper)
      8'h00: begin
        raw = sum[63:0];
        cf  = sum[w];
      end
      8'h01: begin
        raw = am - bm;
        cf  = am < bm;
      end
      8'h02: raw = am & bm;
      8'h03: raw = am | bm;
      8'h04: raw = am ^ bm;
      8'h05: begin
        raw = b;
        mov = 1'b1;
      end
      8'h06: begin
        if (cnt == 7'd0) raw = am;
        else if (cnt >= w) raw = '0;
        else begin
          raw = am << cnt;
          idx = w - cnt;
          cf  = a[idx[5:0]];
        end
      end
      8'h07: begin
        if (cnt == 7'd0) raw = am;
        else if (cnt >= w) raw = '0;
        else begin
          raw = am >> cnt;
          idx = cnt - 7'd1;
          cf  = a[idx[5:0]];
        end
      end
`ifdef EXEC_MUL_EN
      8'h08: is_mul = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
    alu_res   = merge(raw, a, io.in_size);
    alu_flags = mov ? 3'b000 :
                {cf, msb_of(raw, io.in_size),
                 (raw & m) == 64'd0};
  end

  logic        ov_q, we_q;
  logic [63:0] res_q;
  logic [3:0]  dst_q;
  logic [2:0]  fl_q;
  logic        can_load, accept, load_alu;

  assign can_load = !ov_q || io.out_ready;
  assign accept   = io.in_valid && io.in_ready;

`ifdef EXEC_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;

  localparam int ITER = 64 / MUL_BITS;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [63:0] acc_q, mcand_q, mplier_q, op1_q;
  logic [1:0]  sz_q;
  logic [3:0]  mdst_q;
  logic [63:0] step, mul_res;
  logic [2:0]  mul_flags;
  logic        mul_start, mul_done;

  assign io.in_ready = !reset && can_load &&
                       (state_q == IDLE);
  assign load_alu = accept && !io.in_nop &&
                    legal && !is_mul;

  always_comb begin
    step = acc_q + mcand_q *
           64'(mplier_q[MUL_BITS-1:0]);
    mul_res   = merge(step, op1_q, sz_q);
    mul_flags = {1'b0, msb_of(step, sz_q),
                 (step & wmask(sz_q)) == 64'd0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && !io.in_nop && is_mul) begin
          mul_start = 1'b1;
          state_d   = MUL;
        end
      end
      MUL: begin
        if (cnt_q == 8'd1 && can_load) begin
          mul_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Final step is held until the output register can take it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      op1_q    <= '0;
      sz_q     <= '0;
      mdst_q   <= '0;
    end else if (mul_start) begin
      cnt_q    <= 8'(ITER);
      acc_q    <= '0;
      mcand_q  <= io.in_oper1;
      mplier_q <= io.in_oper2;
      op1_q    <= io.in_oper1;
      sz_q     <= io.in_size;
      mdst_q   <= io.in_dstreg;
    end else if (state_q == MUL &&
                 !(cnt_q == 8'd1 && !can_load)) begin
      acc_q    <= step;
      mcand_q  <= mcand_q << MUL_BITS;
      mplier_q <= mplier_q >> MUL_BITS;
      cnt_q    <= cnt_q - 8'd1;
    end
  end
`else
  assign io.in_ready = !reset && can_load;
  assign load_alu = accept && !io.in_nop && legal;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ov_q  <= 1'b0;
      we_q  <= 1'b0;
      res_q <= '0;
      dst_q <= '0;
      fl_q  <= '0;
    end else if (load_alu) begin
      ov_q  <= 1'b1;
      we_q  <= 1'b1;
      res_q <= alu_res;
      dst_q <= io.in_dstreg;
      fl_q  <= alu_flags;
`ifdef EXEC_MUL_EN
    end else if (mul_done) begin
      ov_q  <= 1'b1;
      we_q  <= 1'b1;
      res_q <= mul_res;
      dst_q <= mdst_q;
      fl_q  <= mul_flags;
`endif
    end else if (io.out_ready) begin
      ov_q  <= 1'b0;
    end
  end

  assign io.out_valid  = ov_q;
  assign io.out_result = res_q;
  assign io.out_dstreg = dst_q;
  assign io.out_we     = we_q;
  assign io.out_flags  = fl_q;

endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed and randomized checks of exec_stage
// against an arithmetic reference model (honours EXEC_MUL_EN).
module tb_exec_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  exec_stage_if io ();

  exec_stage #(.MUL_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  dst;
    logic [2:0]  fl;
  } exp_t;

  exp_t q[$];

  function automatic void model(
    input  logic [7:0]  op,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [1:0]  sz,
    output bit          has,
    output logic [63:0] res,
    output logic [2:0]  fl
  );
    int w, sh;
    logic [63:0] m, am, bm, r;
    logic [64:0] t;
    bit cf;
    w   = 8 << sz;
    m   = (w == 64) ? ~64'd0 : (64'd1 << w) - 64'd1;
    am  = a & m;
    bm  = b & m;
    sh  = (sz == 2'd3) ? int'(b[5:0]) : int'(b[4:0]);
    has = 1;
    cf  = 0;
    r   = '0;
    case (op)
      8'h00: begin
        t  = {1'b0, am} + {1'b0, bm};
        r  = t[63:0];
        cf = t[w];
      end
      8'h01: begin r = am - bm; cf = am < bm; end
      8'h02: r = a & b;
      8'h03: r = a | b;
      8'h04: r = a ^ b;
      8'h05: r = b;
      8'h06: begin
        if (sh == 0) r = a;
        else if (sh >= w) r = '0;
        else begin r = a << sh; cf = a[w - sh]; end
      end
      8'h07: begin
        if (sh == 0) r = a;
        else if (sh >= w) r = '0;
        else begin r = am >> sh; cf = a[sh - 1]; end
      end
`ifdef EXEC_MUL_EN
      8'h08: r = a * b;
`endif
      default: has = 0;
    endcase
    r   = r & m;
    res = (sz >= 2'd2) ? r : ((a & ~m) | r);
    fl  = {cf, r[w-1], r == 64'd0};
    if (op == 8'h05) fl = 3'b000;
  endfunction

  task automatic idle_in();
    io.in_valid  = 0;
    io.in_nop    = 0;
    io.in_oper   = '0;
    io.in_oper1  = '0;
    io.in_oper2  = '0;
    io.in_dstreg = '0;
    io.in_size   = '0;
  endtask

  task automatic put(
    input logic [7:0]  op,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [3:0]  dst,
    input logic [1:0]  sz,
    input logic        nop
  );
    io.in_valid  = 1;
    io.in_nop    = nop;
    io.in_oper   = op;
    io.in_oper1  = a;
    io.in_oper2  = b;
    io.in_dstreg = dst;
    io.in_size   = sz;
  endtask

  task automatic test_reset();
    idle_in();
    io.out_ready = 1;
    reset = 1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (io.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_ready got %b want 0", io.in_ready);
    end
    reset = 0;
    #1;
    n_vec++;
    if (io.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_in_ready got %b want 1", io.in_ready);
    end
    n_vec++;
    if ({io.out_valid, io.out_result, io.out_dstreg,
         io.out_we, io.out_flags} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got v%b r%h d%h w%b f%b want 0",
               io.out_valid, io.out_result, io.out_dstreg,
               io.out_we, io.out_flags);
    end
  endtask

  task automatic test_directed();
    logic [7:0]  op  [4] = '{8'h00, 8'h01, 8'h01, 8'h06};
    logic [63:0] a   [4] = '{64'hffff_ffff_ffff_ffff,
                             64'h1122_3344_5566_7700,
                             64'h1122_3344_5566_7700,
                             64'h0000_0000_8000_0001};
    logic [63:0] b   [4] = '{64'd1, 64'h01, 64'h01, 64'h21};
    logic [1:0]  sz  [4] = '{2'd3, 2'd0, 2'd2, 2'd2};
    logic [63:0] er  [4] = '{64'd0,
                             64'h1122_3344_5566_77ff,
                             64'h0000_0000_5566_76ff,
                             64'h0000_0000_0000_0002};
    logic [2:0]  ef  [4] = '{3'b101, 3'b110, 3'b000, 3'b100};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      io.out_ready = 1;
      put(op[i], a[i], b[i], 4'(i + 3), sz[i], 0);
      @(negedge clk);
      io.in_valid = 0;
      n_vec++;
      if (io.out_valid !== 1'b1 || io.out_result !== er[i] ||
          io.out_flags !== ef[i] || io.out_we !== 1'b1 ||
          io.out_dstreg !== 4'(i + 3)) begin
        n_err++;
        $display("FAIL directed%0d got v%b r%h f%b d%h w%b want r%h f%b d%h",
                 i, io.out_valid, io.out_result, io.out_flags,
                 io.out_dstreg, io.out_we, er[i], ef[i], 4'(i + 3));
      end
    end
  endtask

  task automatic test_mul();
    bit seen;
    @(negedge clk);
    io.out_ready = 1;
    put(8'h08, 64'h1_0000_0001, 64'd3, 4'd5, 2'd3, 0);
    @(negedge clk);
    io.in_valid = 0;
`ifdef EXEC_MUL_EN
    for (int k = 0; k < 16; k++) begin
      n_vec++;
      if (io.in_ready !== 1'b0 || io.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL mul_stall%0d got rdy%b v%b want rdy0 v0",
                 k, io.in_ready, io.out_valid);
      end
      @(negedge clk);
    end
    n_vec++;
    if (io.out_valid !== 1'b1 || io.in_ready !== 1'b1 ||
        io.out_result !== 64'h3_0000_0003 ||
        io.out_flags !== 3'b000 || io.out_dstreg !== 4'd5) begin
      n_err++;
      $display("FAIL mul_result got v%b rdy%b r%h f%b d%h want v1 rdy1 r300000003 f000 d5",
               io.out_valid, io.in_ready, io.out_result,
               io.out_flags, io.out_dstreg);
    end
`else
    seen = 0;
    repeat (20) begin
      if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) seen = 1;
      @(negedge clk);
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL mul_disabled got output_or_stall=1 want 0");
    end
`endif
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    idle_in();
    io.out_ready = 1;
    @(negedge clk);
    io.out_ready = 0;
    put(8'h00, 64'h100, 64'h23, 4'd1, 2'd3, 0);
    @(negedge clk);
    n_vec++;
    if (io.out_valid !== 1'b1 || io.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_first got v%b rdy%b want v1 rdy0",
               io.out_valid, io.in_ready);
    end
    put(8'h00, 64'h5, 64'h7, 4'd2, 2'd3, 0);
    repeat (3) begin
      @(negedge clk);
      n_vec++;
      if (io.out_result !== 64'h123 || io.out_dstreg !== 4'd1 ||
          io.out_valid !== 1'b1 || io.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold got r%h d%h v%b rdy%b want r123 d1 v1 rdy0",
                 io.out_result, io.out_dstreg, io.out_valid, io.in_ready);
      end
    end
    io.out_ready = 1;
    #1;
    n_vec++;
    if (io.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release_ready got %b want 1", io.in_ready);
    end
    @(negedge clk);
    io.in_valid = 0;
    n_vec++;
    if (io.out_valid !== 1'b1 || io.out_result !== 64'hc ||
        io.out_dstreg !== 4'd2) begin
      n_err++;
      $display("FAIL bp_second got v%b r%h d%h want v1 rc d2",
               io.out_valid, io.out_result, io.out_dstreg);
    end
    @(negedge clk);
    n_vec++;
    if (io.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain got v%b want 0", io.out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    bit seen;
    @(negedge clk);
    io.out_ready = 1;
    put(8'h08, {$urandom, $urandom}, {$urandom, $urandom},
        4'd7, 2'd3, 0);
    @(negedge clk);
    io.in_valid = 0;
    repeat (4) @(negedge clk);
    reset = 1;
    #1;
    n_vec++;
    if (io.out_valid !== 1'b0 || io.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_mul_reset got v%b rdy%b want v0 rdy0",
               io.out_valid, io.in_ready);
    end
    @(negedge clk);
    reset = 0;
    #1;
    n_vec++;
    if (io.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_mul_release got rdy%b want 1", io.in_ready);
    end
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (io.out_valid !== 1'b0) seen = 1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL mid_mul_leak got out_valid=1 want 0");
    end
  endtask

  task automatic test_nop();
    bit seen, stall;
    seen  = 0;
    stall = 0;
    @(negedge clk);
    io.out_ready = 1;
    put(8'h00, 64'd1, 64'd2, 4'd4, 2'd3, 1);
    @(negedge clk);
    if (io.in_ready !== 1'b1) stall = 1;
    put(8'h3c, 64'd1, 64'd2, 4'd4, 2'd3, 0);
    @(negedge clk);
    if (io.in_ready !== 1'b1) stall = 1;
    io.in_valid = 0;
    repeat (5) begin
      if (io.out_valid !== 1'b0) seen = 1;
      @(negedge clk);
    end
    n_vec++;
    if (seen || stall) begin
      n_err++;
      $display("FAIL nop_illegal got out=%0d stall=%0d want 0 0",
               seen, stall);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (io.out_valid && io.out_ready) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL rand_unexpected got r%h want none",
                 io.out_result);
      end else begin
        e = q.pop_front();
        if (io.out_result !== e.res || io.out_flags !== e.fl ||
            io.out_dstreg !== e.dst || io.out_we !== 1'b1) begin
          n_err++;
          $display("FAIL rand_result got r%h f%b d%h w%b want r%h f%b d%h",
                   io.out_result, io.out_flags, io.out_dstreg,
                   io.out_we, e.res, e.fl, e.dst);
        end
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    bit   has;
    q.delete();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      io.in_valid  = ($urandom_range(0, 3) != 0);
      io.in_nop    = ($urandom_range(0, 7) == 0);
      io.in_oper   = 8'($urandom_range(0, 10));
      io.in_oper1  = {$urandom, $urandom};
      io.in_oper2  = $urandom_range(0, 1) ?
                     64'($urandom_range(0, 70)) :
                     {$urandom, $urandom};
      io.in_dstreg = 4'($urandom);
      io.in_size   = 2'($urandom);
      io.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check_out();
      if (io.in_valid && io.in_ready && !io.in_nop) begin
        model(io.in_oper, io.in_oper1, io.in_oper2,
              io.in_size, has, e.res, e.fl);
        e.dst = io.in_dstreg;
        if (has) q.push_back(e);
      end
    end
    @(negedge clk);
    idle_in();
    io.out_ready = 1;
    for (int c = 0; c < 100; c++) begin
      #1;
      check_out();
      @(negedge clk);
    end
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL rand_missing got %0d pending want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_nop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
